// File: rtl/robot_sensor_conditioner_pkg.sv
// Shared constants and types for the robot sensor conditioning stage.
package robot_sensor_pkg;

    localparam int unsigned N_SENSOR = 5;

    localparam int unsigned CH_X1 = 0;
    localparam int unsigned CH_X2 = 1;
    localparam int unsigned CH_X3 = 2;
    localparam int unsigned CH_X4 = 3;
    localparam int unsigned CH_X5 = 4;

    typedef enum logic {DEB_STABLE, DEB_COUNTING} deb_state_t;

endpackage

// File: rtl/robot_sensor_conditioner_debounce.sv
// One sensor channel: 2-FF synchroniser, debounce FSM, edge pulses and the
// optional stuck-input watchdog (enabled with SENSOR_WATCHDOG_EN).
module sensor_debounce_ch
    import robot_sensor_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic stable_o,
    output logic stuck_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES == 0 || (DEB_CYCLES - 1) >= (1 << CNT_W) || WDOG_CYCLES > 65535) begin : g_bad_param
        $error("sensor_debounce_ch: illegal DEB_CYCLES/CNT_W/WDOG_CYCLES");
    end

    logic             meta_q, sync_q;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            DEB_STABLE: begin
                if (sync_q != level_q && en_i) begin
                    if (DEB_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = DEB_COUNTING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            DEB_COUNTING: begin
                // A bounce back to the accepted level cancels even on a non-tick cycle.
                if (sync_q == level_q) begin
                    state_d = DEB_STABLE;
                    cnt_d   = '0;
                end else if (en_i) begin
                    if (cnt_q == CNT_LAST) accept = 1'b1;
                    else                   cnt_d  = cnt_q + CNT_W'(1);
                end
            end
        endcase
        if (accept) begin
            state_d = DEB_STABLE;
            cnt_d   = '0;
            level_d = sync_q;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= DEB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign stable_o = (state_q == DEB_STABLE);

`ifdef SENSOR_WATCHDOG_EN
    localparam logic [15:0] WD_MAX = 16'(WDOG_CYCLES);

    logic [15:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (accept)                       wd_d = '0;
        else if (en_i && wd_q != WD_MAX)  wd_d = wd_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign stuck_o = (wd_q == WD_MAX);
`else
    assign stuck_o = 1'b0;
`endif

endmodule

// File: rtl/robot_sensor_conditioner.sv
// Sensor input conditioner feeding controller inputs x1..x5; one debounce
// channel per sensor. Optional watchdog via SENSOR_WATCHDOG_EN.
module robot_sensor_conditioner
    import robot_sensor_pkg::*;
#(
    parameter int unsigned N_CH        = N_SENSOR,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] sensor_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            settled,
    output logic [N_CH-1:0] stuck
);

    logic [N_CH-1:0] stable;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sensor_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W),
            .WDOG_CYCLES (WDOG_CYCLES)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .en_i     (en),
            .raw_i    (raw_in[i]),
            .level_o  (sensor_out[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i]),
            .stable_o (stable[i]),
            .stuck_o  (stuck[i])
        );
    end

    assign settled = &stable;

endmodule
